cgra_ker_req_arbiter: RTL and testbench

CGRA_KER_REQ_ARBITER -- requirements
Module: cgra_ker_req_arbiter

---
 rtl/cgra_ker_req_arbiter.sv | 160 ++++++++++++++++
 tb/tb_cgra_ker_req_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cgra_ker_req_arbiter.sv
// Round-robin arbiter that collects kernel-launch requests from N_REQ sources into a small FIFO
// and presents them one at a time to the CGRA synchronizer, with a one-cycle gap between issues.
module cgra_ker_req_arbiter #(
  parameter  int N_REQ    = 4,
  parameter  int KER_ID_W = 4,
  parameter  int DEPTH    = 4,
  localparam int SRC_W    = $clog2(N_REQ),
  localparam int PTR_W    = $clog2(DEPTH),
  localparam int CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [N_REQ-1:0]          req_valid_i,
  input  logic [N_REQ*KER_ID_W-1:0] req_ker_id_i,
  output logic [N_REQ-1:0]          req_ready_o,
  output logic                      ker_valid_o,
  output logic [KER_ID_W-1:0]       ker_id_o,
  output logic [SRC_W-1:0]          ker_src_o,
  input  logic                      ker_ack_i,
  output logic                      drop_o,
  output logic [CNT_W-1:0]          fifo_cnt_o,
  output logic                      full_o,
  output logic                      empty_o
);

  localparam int ENT_W = SRC_W + KER_ID_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SRC_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic               drop_q, drop_d;
  logic [ENT_W-1:0]   mem_q [DEPTH];

  logic               full;
  logic               empty;
  logic               pop;
  logic               push;
  logic               grant;
  logic               gnt_found;
  logic [SRC_W-1:0]   gnt_idx;
  logic [SRC_W:0]     search_sum;
  logic [SRC_W-1:0]   search_idx;
  logic [KER_ID_W-1:0] gnt_id;
  logic [ENT_W-1:0]   head;

  assign full  = (cnt_q == CNT_W'(DEPTH));
  assign empty = (cnt_q == '0);
  assign pop   = (state_q == ST_ISSUE) && ker_ack_i;

  // Search for the first valid requester starting at the round-robin pointer, wrapping modulo N_REQ.
  always_comb begin
    gnt_found  = 1'b0;
    gnt_idx    = '0;
    search_sum = '0;
    search_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      search_sum = {1'b0, rr_ptr_q} + (SRC_W+1)'(i);
      if (search_sum >= (SRC_W+1)'(N_REQ)) begin
        search_sum = search_sum - (SRC_W+1)'(N_REQ);
      end
      search_idx = search_sum[SRC_W-1:0];
      if (!gnt_found && req_valid_i[search_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = search_idx;
      end
    end
  end

  always_comb begin
    gnt_id = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_idx == SRC_W'(i)) begin
        gnt_id = req_ker_id_i[i*KER_ID_W +: KER_ID_W];
      end
    end
  end

  // A full FIFO can still accept when the head is popped in the same cycle.
  assign grant  = gnt_found && (!full || pop) && !rst_i;
  assign push   = grant && (gnt_id != '0);
  assign drop_d = grant && (gnt_id == '0);

  always_comb begin
    req_ready_o = '0;
    for (int i = 0; i < N_REQ; i++) begin
      req_ready_o[i] = grant && (gnt_idx == SRC_W'(i));
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant) begin
      rr_ptr_d = (gnt_idx == SRC_W'(N_REQ - 1)) ? '0 : gnt_idx + SRC_W'(1);
    end
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    cnt_d    = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (!empty) state_d = ST_ISSUE;
      ST_ISSUE: if (ker_ack_i) state_d = ST_GAP;
      ST_GAP:   state_d = (cnt_d != '0) ? ST_ISSUE : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      rr_ptr_q <= '0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      rr_ptr_q <= rr_ptr_d;
      drop_q   <= drop_d;
    end
  end

  // Storage needs no reset: its contents are only visible through the count-qualified head.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {gnt_idx, gnt_id};
    end
  end

  assign head        = mem_q[rd_ptr_q];
  assign ker_valid_o = (state_q == ST_ISSUE);
  assign ker_id_o    = ker_valid_o ? head[KER_ID_W-1:0] : '0;
  assign ker_src_o   = ker_valid_o ? head[ENT_W-1:KER_ID_W] : '0;
  assign drop_o      = drop_q;
  assign fifo_cnt_o  = cnt_q;
  assign full_o      = full;
  assign empty_o     = empty;

endmodule

// File: tb/tb_cgra_ker_req_arbiter.sv
// Directed testbench for cgra_ker_req_arbiter: each task drives one scenario and checks inline.
module tb_cgra_ker_req_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [15:0] req_ker_id = '0;
  logic [3:0]  req_ready;
  logic        ker_valid;
  logic [3:0]  ker_id;
  logic [1:0]  ker_src;
  logic        ker_ack = 1'b0;
  logic        drop;
  logic [2:0]  fifo_cnt;
  logic        full;
  logic        empty;

  int tests_run = 0;
  int tests_failed = 0;

  cgra_ker_req_arbiter #(.N_REQ(4), .KER_ID_W(4), .DEPTH(4)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (req_valid),
    .req_ker_id_i (req_ker_id),
    .req_ready_o  (req_ready),
    .ker_valid_o  (ker_valid),
    .ker_id_o     (ker_id),
    .ker_src_o    (ker_src),
    .ker_ack_i    (ker_ack),
    .drop_o       (drop),
    .fifo_cnt_o   (fifo_cnt),
    .full_o       (full),
    .empty_o      (empty)
  );

  always #5 clk = ~clk;

  // Inputs change 2 time units after the rising edge; outputs are sampled 1 unit later.
  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset;
    rst = 1'b1; req_valid = '0; req_ker_id = '0; ker_ack = 1'b0;
    tick; tick;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    #3;
    req_valid = 4'hF; req_ker_id = 16'h4321;
    rst = 1'b1;
    #1;
    tests_run++; if (ker_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_valid: got %0h expected 0", ker_valid); end
    tests_run++; if (ker_id !== 4'd0) begin tests_failed++; $display("[TB] FAIL reset_id: got %0h expected 0", ker_id); end
    tests_run++; if (ker_src !== 2'd0) begin tests_failed++; $display("[TB] FAIL reset_src: got %0h expected 0", ker_src); end
    tests_run++; if (drop !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_drop: got %0h expected 0", drop); end
    tests_run++; if (empty !== 1'b1 || full !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_flags: got empty=%0h full=%0h expected empty=1 full=0", empty, full); end
    tests_run++; if (fifo_cnt !== 3'd0) begin tests_failed++; $display("[TB] FAIL reset_cnt: got %0d expected 0", fifo_cnt); end
    tests_run++; if (req_ready !== 4'b0000) begin tests_failed++; $display("[TB] FAIL reset_ready: got %b expected 0000", req_ready); end
    tick;
    tests_run++; if (req_ready !== 4'b0000 || ker_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_hold: got ready=%b valid=%0h expected ready=0000 valid=0", req_ready, ker_valid); end
    req_valid = '0; req_ker_id = '0;
    rst = 1'b0;
  endtask

  task automatic test_single;
    do_reset;
    req_valid = 4'b0100; req_ker_id = 16'h0500;
    #1;
    tests_run++; if (req_ready !== 4'b0100) begin tests_failed++; $display("[TB] FAIL single_ready: got %b expected 0100", req_ready); end
    tick;
    req_valid = '0; req_ker_id = '0;
    #1;
    tests_run++; if (req_ready !== 4'b0000 || ker_valid !== 1'b0 || fifo_cnt !== 3'd1) begin tests_failed++; $display("[TB] FAIL single_n1: got ready=%b valid=%0h cnt=%0d expected 0000/0/1", req_ready, ker_valid, fifo_cnt); end
    tick; #1;
    tests_run++; if (ker_valid !== 1'b1 || ker_id !== 4'd5 || ker_src !== 2'd2) begin tests_failed++; $display("[TB] FAIL single_issue: got valid=%0h id=%0d src=%0d expected 1/5/2", ker_valid, ker_id, ker_src); end
    ker_ack = 1'b1;
    tick;
    ker_ack = 1'b0;
    #1;
    tests_run++; if (ker_valid !== 1'b0 || empty !== 1'b1 || ker_id !== 4'd0) begin tests_failed++; $display("[TB] FAIL single_gap: got valid=%0h empty=%0h id=%0d expected 0/1/0", ker_valid, empty, ker_id); end
    tick; #1;
    tests_run++; if (ker_valid !== 1'b0 || empty !== 1'b1) begin tests_failed++; $display("[TB] FAIL single_idle: got valid=%0h empty=%0h expected 0/1", ker_valid, empty); end
  endtask

  task automatic test_fairness;
    int sb[$];
    int exp_gnt;
    int grants;
    bit drained;
    do_reset;
    exp_gnt = 0; grants = 0; drained = 1'b0;
    req_valid = 4'hF; req_ker_id = 16'h4321;
    for (int c = 0; c < 40; c++) begin
      ker_ack = ker_valid;
      #1;
      if (ker_ack) begin
        tests_run++;
        if (sb.size() == 0) begin tests_failed++; $display("[TB] FAIL fair_issue_unexpected: got src=%0d expected no issue", ker_src); end
        else begin
          if (ker_src !== 2'(sb[0]) || ker_id !== 4'(sb[0] + 1)) begin tests_failed++; $display("[TB] FAIL fair_issue: got src=%0d id=%0d expected src=%0d id=%0d", ker_src, ker_id, sb[0], sb[0] + 1); end
          void'(sb.pop_front());
        end
      end
      if (req_ready !== 4'b0000) begin
        tests_run++; if (req_ready !== 4'(1 << exp_gnt)) begin tests_failed++; $display("[TB] FAIL fair_grant: got %b expected one-hot %0d", req_ready, exp_gnt); end
        sb.push_back(exp_gnt);
        exp_gnt = (exp_gnt + 1) % 4;
        grants++;
      end
      tick;
    end
    req_valid = '0; req_ker_id = '0;
    for (int c = 0; c < 40 && !drained; c++) begin
      if (empty && !ker_valid) drained = 1'b1;
      else begin
        ker_ack = ker_valid;
        #1;
        if (ker_ack && sb.size() != 0) begin
          tests_run++; if (ker_src !== 2'(sb[0]) || ker_id !== 4'(sb[0] + 1)) begin tests_failed++; $display("[TB] FAIL fair_drain: got src=%0d id=%0d expected src=%0d id=%0d", ker_src, ker_id, sb[0], sb[0] + 1); end
          void'(sb.pop_front());
        end
        tick;
      end
    end
    ker_ack = 1'b0;
    tests_run++; if (!drained || sb.size() != 0) begin tests_failed++; $display("[TB] FAIL fair_drain_done: got drained=%0d left=%0d expected drained=1 left=0", drained, sb.size()); end
    tests_run++; if (grants < 16) begin tests_failed++; $display("[TB] FAIL fair_grant_count: got %0d expected at least 16", grants); end
  endtask

  task automatic test_full;
    do_reset;
    for (int k = 0; k < 4; k++) begin
      req_valid = 4'b0001; req_ker_id = {12'h000, 4'(k + 1)};
      #1;
      tests_run++; if (req_ready !== 4'b0001) begin tests_failed++; $display("[TB] FAIL full_fill_ready: got %b expected 0001 (entry %0d)", req_ready, k); end
      tick;
    end
    #1;
    tests_run++; if (full !== 1'b1 || fifo_cnt !== 3'd4 || req_ready !== 4'b0000) begin tests_failed++; $display("[TB] FAIL full_state: got full=%0h cnt=%0d ready=%b expected 1/4/0000", full, fifo_cnt, req_ready); end
    tests_run++; if (ker_valid !== 1'b1 || ker_id !== 4'd1) begin tests_failed++; $display("[TB] FAIL full_head: got valid=%0h id=%0d expected 1/1", ker_valid, ker_id); end
    req_valid = 4'b0010; req_ker_id = 16'h0090; ker_ack = 1'b1;
    #1;
    tests_run++; if (req_ready !== 4'b0010) begin tests_failed++; $display("[TB] FAIL full_pushpop_ready: got %b expected 0010", req_ready); end
    tick;
    ker_ack = 1'b0; req_valid = '0; req_ker_id = '0;
    #1;
    tests_run++; if (fifo_cnt !== 3'd4 || full !== 1'b1 || ker_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL full_pushpop_cnt: got cnt=%0d full=%0h valid=%0h expected 4/1/0", fifo_cnt, full, ker_valid); end
    tick; #1;
    tests_run++; if (ker_valid !== 1'b1 || ker_id !== 4'd2 || ker_src !== 2'd0) begin tests_failed++; $display("[TB] FAIL full_next_head: got valid=%0h id=%0d src=%0d expected 1/2/0", ker_valid, ker_id, ker_src); end
  endtask

  task automatic test_zero_id;
    do_reset;
    req_valid = 4'b1000; req_ker_id = 16'h0000;
    #1;
    tests_run++; if (req_ready !== 4'b1000 || drop !== 1'b0) begin tests_failed++; $display("[TB] FAIL zero_ready: got ready=%b drop=%0h expected 1000/0", req_ready, drop); end
    tick;
    req_valid = '0;
    #1;
    tests_run++; if (drop !== 1'b1 || fifo_cnt !== 3'd0 || ker_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL zero_drop: got drop=%0h cnt=%0d valid=%0h expected 1/0/0", drop, fifo_cnt, ker_valid); end
    tick; #1;
    tests_run++; if (drop !== 1'b0 || ker_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL zero_drop_end: got drop=%0h valid=%0h expected 0/0", drop, ker_valid); end
    tick; #1;
    tests_run++; if (ker_valid !== 1'b0 || empty !== 1'b1) begin tests_failed++; $display("[TB] FAIL zero_no_issue: got valid=%0h empty=%0h expected 0/1", ker_valid, empty); end
    // A dropped grant from requester 1 must still move the search start to 2.
    req_valid = 4'b0010; req_ker_id = 16'h0000;
    tick;
    req_valid = 4'b1001; req_ker_id = 16'h3001;
    #1;
    tests_run++; if (req_ready !== 4'b1000) begin tests_failed++; $display("[TB] FAIL zero_rr_advance: got %b expected 1000", req_ready); end
    tick;
    req_valid = '0; req_ker_id = '0;
  endtask

  task automatic test_wrap;
    int sb_id[$];
    int sb_src[$];
    int next_id;
    int popped;
    int src;
    bit pending;
    do_reset;
    next_id = 1; popped = 0; pending = 1'b0; src = 0;
    for (int c = 0; c < 200 && popped < 10; c++) begin
      if (!pending && next_id <= 10 && (c % 3) != 2) begin
        pending = 1'b1;
        src = next_id % 4;
        req_ker_id = '0;
        req_ker_id[src*4 +: 4] = 4'(next_id);
        req_valid = 4'(1 << src);
      end
      ker_ack = ker_valid && ((c % 4) != 1);
      #1;
      if (ker_ack) begin
        tests_run++;
        if (sb_id.size() == 0) begin tests_failed++; $display("[TB] FAIL wrap_unexpected: got id=%0d expected no issue", ker_id); end
        else begin
          if (ker_id !== 4'(sb_id[0]) || ker_src !== 2'(sb_src[0])) begin tests_failed++; $display("[TB] FAIL wrap_order: got id=%0d src=%0d expected id=%0d src=%0d", ker_id, ker_src, sb_id[0], sb_src[0]); end
          void'(sb_id.pop_front());
          void'(sb_src.pop_front());
          popped++;
        end
      end
      if (pending && req_ready !== 4'b0000) begin
        tests_run++; if (req_ready !== req_valid) begin tests_failed++; $display("[TB] FAIL wrap_grant: got %b expected %b", req_ready, req_valid); end
        sb_id.push_back(next_id);
        sb_src.push_back(src);
        next_id++;
        pending = 1'b0;
      end
      tick;
      if (!pending) begin req_valid = '0; req_ker_id = '0; end
    end
    ker_ack = 1'b0; req_valid = '0; req_ker_id = '0;
    tests_run++; if (popped != 10 || next_id != 11) begin tests_failed++; $display("[TB] FAIL wrap_count: got popped=%0d pushed=%0d expected 10/10", popped, next_id - 1); end
    #1;
    tests_run++; if (empty !== 1'b1 || fifo_cnt !== 3'd0) begin tests_failed++; $display("[TB] FAIL wrap_empty: got empty=%0h cnt=%0d expected 1/0", empty, fifo_cnt); end
  endtask

  task automatic test_reset_mid;
    do_reset;
    req_valid = 4'b0111; req_ker_id = 16'h0321;
    tick; tick; tick;
    req_valid = '0; req_ker_id = '0;
    #1;
    tests_run++; if (ker_valid !== 1'b1 || fifo_cnt !== 3'd3 || ker_id !== 4'd1) begin tests_failed++; $display("[TB] FAIL mid_setup: got valid=%0h cnt=%0d id=%0d expected 1/3/1", ker_valid, fifo_cnt, ker_id); end
    req_valid = 4'b0010; req_ker_id = 16'h0070;
    rst = 1'b1;
    #1;
    tests_run++; if (ker_valid !== 1'b0 || ker_id !== 4'd0 || ker_src !== 2'd0 || drop !== 1'b0) begin tests_failed++; $display("[TB] FAIL mid_async_out: got valid=%0h id=%0d src=%0d drop=%0h expected 0/0/0/0", ker_valid, ker_id, ker_src, drop); end
    tests_run++; if (empty !== 1'b1 || full !== 1'b0 || fifo_cnt !== 3'd0 || req_ready !== 4'b0000) begin tests_failed++; $display("[TB] FAIL mid_async_fifo: got empty=%0h full=%0h cnt=%0d ready=%b expected 1/0/0/0000", empty, full, fifo_cnt, req_ready); end
    tick;
    req_valid = '0; req_ker_id = '0;
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      tests_run++; if (ker_valid !== 1'b0 || empty !== 1'b1) begin tests_failed++; $display("[TB] FAIL mid_quiet: got valid=%0h empty=%0h expected 0/1 (cycle %0d)", ker_valid, empty, c); end
      tick;
    end
    req_valid = 4'b0100; req_ker_id = 16'h0600;
    #1;
    tests_run++; if (req_ready !== 4'b0100) begin tests_failed++; $display("[TB] FAIL mid_new_ready: got %b expected 0100", req_ready); end
    tick;
    req_valid = '0; req_ker_id = '0;
    tick; #1;
    tests_run++; if (ker_valid !== 1'b1 || ker_id !== 4'd6 || ker_src !== 2'd2) begin tests_failed++; $display("[TB] FAIL mid_new_issue: got valid=%0h id=%0d src=%0d expected 1/6/2", ker_valid, ker_id, ker_src); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_fairness;
    test_full;
    test_zero_id;
    test_wrap;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

endmodule
